hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/hazard_ctrl_if.sv | 43 ++++
 rtl/forwarding_unit.sv | 22 ++
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared types and constants for the pipeline hazard controller (rev 1.0)
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } hz_state_e;

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  localparam int FLUSH_CYCLES_DEFAULT = 2;

  // The younger producer (EX/MEM) wins over MEM/WB; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       exm_we,
                                         input logic [4:0] exm_rd,
                                         input logic       mwb_we,
                                         input logic [4:0] mwb_rd);
    if (exm_we && (exm_rd != 5'd0) && (exm_rd == src)) return FWD_EX_MEM;
    if (mwb_we && (mwb_rd != 5'd0) && (mwb_rd == src)) return FWD_MEM_WB;
    return FWD_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- pipeline status in, stall/flush/forward controls out (rev 1.0)
`default_nettype none

interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_rs1, ID_rs2;
  logic             ID_uses_rs1, ID_uses_rs2;
  logic [4:0]       EX_rs1, EX_rs2;
  logic [4:0]       ID_EX_rd;
  logic             ID_EX_memread, ID_EX_regwrite;
  logic [4:0]       EX_MEM_rd;
  logic             EX_MEM_regwrite, EX_MEM_flush;
  logic [4:0]       MEM_WB_rd;
  logic             MEM_WB_regwrite;
  logic             mem_busy;

  logic             pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall;
  logic             ID_EX_bubble;
  logic             IF_ID_flush, ID_EX_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_count, flush_count;

  modport master (
    output ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, EX_rs1, EX_rs2,
           ID_EX_rd, ID_EX_memread, ID_EX_regwrite,
           EX_MEM_rd, EX_MEM_regwrite, EX_MEM_flush,
           MEM_WB_rd, MEM_WB_regwrite, mem_busy,
    input  pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, ID_EX_bubble,
           IF_ID_flush, ID_EX_flush, fwd_a, fwd_b, stall_count, flush_count
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, EX_rs1, EX_rs2,
           ID_EX_rd, ID_EX_memread, ID_EX_regwrite,
           EX_MEM_rd, EX_MEM_regwrite, EX_MEM_flush,
           MEM_WB_rd, MEM_WB_regwrite, mem_busy,
    output pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, ID_EX_bubble,
           IF_ID_flush, ID_EX_flush, fwd_a, fwd_b, stall_count, flush_count
  );
endinterface

`default_nettype wire

// File: rtl/forwarding_unit.sv
// forwarding_unit -- combinational operand bypass select for both execute sources (rev 1.0)
`default_nettype none

module forwarding_unit
  import hazard_pkg::*;
(
  input  logic [4:0] ex_rs1_i,
  input  logic [4:0] ex_rs2_i,
  input  logic       ex_mem_we_i,
  input  logic [4:0] ex_mem_rd_i,
  input  logic       mem_wb_we_i,
  input  logic [4:0] mem_wb_rd_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  assign fwd_a_o = fwd_sel(ex_rs1_i, ex_mem_we_i, ex_mem_rd_i, mem_wb_we_i, mem_wb_rd_i);
  assign fwd_b_o = fwd_sel(ex_rs2_i, ex_mem_we_i, ex_mem_rd_i, mem_wb_we_i, mem_wb_rd_i);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- load-use / memory-wait stall, mispredict flush FSM, forwarding and perf counters (rev 1.0)
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  hz_state_e        state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             lu;
  logic             run_eval;
  logic             lu_en;

  forwarding_unit u_fwd (
    .ex_rs1_i    (bus.EX_rs1),
    .ex_rs2_i    (bus.EX_rs2),
    .ex_mem_we_i (bus.EX_MEM_regwrite),
    .ex_mem_rd_i (bus.EX_MEM_rd),
    .mem_wb_we_i (bus.MEM_WB_regwrite),
    .mem_wb_rd_i (bus.MEM_WB_rd),
    .fwd_a_o     (bus.fwd_a),
    .fwd_b_o     (bus.fwd_b)
  );

  assign lu = bus.ID_EX_memread && (bus.ID_EX_rd != 5'd0) &&
              ((bus.ID_uses_rs1 && (bus.ID_rs1 == bus.ID_EX_rd)) ||
               (bus.ID_uses_rs2 && (bus.ID_rs2 == bus.ID_EX_rd)));

  always_comb begin
    state_d          = state_q;
    fcnt_d           = fcnt_q;
    run_eval         = 1'b0;
    lu_en            = 1'b1;
    bus.pc_stall     = 1'b0;
    bus.IF_ID_stall  = 1'b0;
    bus.ID_EX_stall  = 1'b0;
    bus.EX_MEM_stall = 1'b0;
    bus.ID_EX_bubble = 1'b0;
    bus.IF_ID_flush  = 1'b0;
    bus.ID_EX_flush  = 1'b0;

    case (state_q)
      FLUSH: begin
        bus.IF_ID_flush = 1'b1;
        bus.ID_EX_flush = 1'b1;
        if (fcnt_q <= 3'd1) begin
          fcnt_d  = 3'd0;
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_busy) begin
          bus.pc_stall     = 1'b1;
          bus.IF_ID_stall  = 1'b1;
          bus.ID_EX_stall  = 1'b1;
          bus.EX_MEM_stall = 1'b1;
        end else begin
          run_eval = 1'b1;
        end
      end
      LOAD_STALL: begin
        // The load that caused the bubble has moved on; do not bubble again.
        run_eval = 1'b1;
        lu_en    = 1'b0;
      end
      default: run_eval = 1'b1;
    endcase

    if (run_eval) begin
      state_d = RUN;
      if (bus.EX_MEM_flush) begin
        bus.IF_ID_flush = 1'b1;
        bus.ID_EX_flush = 1'b1;
        fcnt_d          = FLUSH_LOAD;
        state_d         = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else if (bus.mem_busy) begin
        bus.pc_stall     = 1'b1;
        bus.IF_ID_stall  = 1'b1;
        bus.ID_EX_stall  = 1'b1;
        bus.EX_MEM_stall = 1'b1;
        state_d          = MEM_WAIT;
      end else if (lu && lu_en) begin
        bus.pc_stall     = 1'b1;
        bus.IF_ID_stall  = 1'b1;
        bus.ID_EX_bubble = 1'b1;
        state_d          = LOAD_STALL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (bus.pc_stall && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (bus.IF_ID_flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.stall_count = stall_q;
  assign bus.flush_count = flush_q;

  a_stall_flush_excl : assert property (@(posedge clk) disable iff (reset)
    !((bus.pc_stall || bus.IF_ID_stall || bus.ID_EX_stall || bus.EX_MEM_stall || bus.ID_EX_bubble) &&
      (bus.IF_ID_flush || bus.ID_EX_flush)));

endmodule

`default_nettype wire
